blake_digest_buffer: RTL

- Output stage directly downstream of the BLAKE-512 round counter/pipeline in the hardware-duplicated core.
- Captures the 512-bit digest on the single-cycle rdy pulse the counter emits 65 cycles after count_done, and queues it in a small FIFO.
- Presents digests to the host side over a valid/ready handshake.
- Issues credits upstream so a new message block is started only when a buffer slot is guaranteed; digests are never dropped by design.

---
 rtl/blake_digest_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/blake_digest_buffer.sv
// Digest output buffer for the BLAKE-512 core: captures pipeline results into a
// small credit-managed FIFO. Optional statistics counters via BLAKE_DBUF_STATS_EN.
module blake_digest_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 512,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_start,
  input  logic          cap_en,
  input  logic [DW-1:0] digest_in,
  output logic          start_ok,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] occupancy,
  output logic [CW-1:0] inflight,
`ifdef BLAKE_DBUF_STATS_EN
  output logic [31:0]   digest_cnt,
  output logic [31:0]   stall_cnt,
`endif
  output logic          err_overflow
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] infl_q, infl_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          start_acc;
  logic          capture;
  logic          pop;

  // Credits count both stored and reserved slots, so a capture always finds room.
  always_comb begin
    start_ok   = ({1'b0, occ_q} + {1'b0, infl_q}) < DEPTH_W;
    dout_valid = (occ_q != '0);
    dout       = mem_q[rd_ptr_q];
    start_acc  = job_start & start_ok;
    capture    = cap_en & (infl_q != '0);
    pop        = dout_valid & dout_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (capture) begin
      mem_d[wr_ptr_q] = digest_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    infl_d = infl_q + CW'(start_acc) - CW'(capture);
    occ_d  = occ_q + CW'(capture) - CW'(pop);
    err_d  = err_q | (job_start & ~start_ok) | (cap_en & (infl_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign occupancy    = occ_q;
  assign inflight     = infl_q;
  assign err_overflow = err_q;

`ifdef BLAKE_DBUF_STATS_EN
  logic [31:0] digest_cnt_q, digest_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    digest_cnt_d = digest_cnt_q + 32'(pop);
    stall_cnt_d  = stall_cnt_q + 32'(dout_valid & ~dout_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digest_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      digest_cnt_q <= digest_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign digest_cnt = digest_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
